// File: rtl/stream_sched_pkg.sv
// Shared types and helpers for the stream evaluation scheduler.
// The event entry struct depends on the top-level widths, so it is declared inside the top.
package stream_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EVAL = 2'd2
  } sched_state_t;

  localparam int MAX_OUT = 32;

  // Periodic outputs follow their deadline bit; event-driven ones follow their input dependencies.
  function automatic logic [MAX_OUT-1:0] active_mask(
    input logic [MAX_OUT-1:0] periodic,
    input logic [MAX_OUT-1:0] per_fire,
    input logic [MAX_OUT-1:0] dep_hit
  );
    return (periodic & per_fire) | (~periodic & dep_hit);
  endfunction

endpackage

// File: rtl/sched_event_fifo.sv
// Small registered FIFO for evaluation events.
// There is no fall-through: an entry pushed into an empty FIFO can be popped one cycle later.
module sched_event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/stream_eval_scheduler.sv
// Turns input arrivals and periodic deadlines into queued evaluation events.
// Each event is replayed as one LOAD cycle followed by one EVAL cycle per layer.
module stream_eval_scheduler
  import stream_sched_pkg::*;
#(
  parameter int N_IN       = 1,
  parameter int N_OUT      = 4,
  parameter int TS_W       = 32,
  parameter int Q_DEPTH    = 4,
  parameter int NUM_LAYERS = 3,
  parameter logic [N_OUT*TS_W-1:0] PERIOD   = '0,
  parameter logic [N_OUT*8-1:0]    LAYER_OF = {8'd2, 8'd1, 8'd1, 8'd0},
  parameter logic [N_OUT*N_IN-1:0] DEP_IN   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_IN-1:0]  new_input,
  output logic [N_IN-1:0]  enable_in,
  output logic [N_OUT-1:0] enable_out,
  output logic             q_push,
  output logic             q_pop,
  output logic             q_push_valid,
  output logic             q_pop_valid,
  output logic [TS_W-1:0]  ev_timestamp,
  output logic             busy,
  output logic             overflow
);

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [N_IN-1:0]  in_mask;
    logic [N_OUT-1:0] per_mask;
  } ev_entry_t;

  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [TS_W-1:0]  ts;
  logic [N_OUT-1:0] per_fire, periodic;
  logic [N_IN-1:0]  in_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ts <= '0;
    else if (en) ts <= ts + TS_W'(1);
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_per
    localparam logic [TS_W-1:0] P = PERIOD[j*TS_W +: TS_W];
    assign periodic[j] = (P != '0);
    if (P != '0) begin : g_cnt
      logic [TS_W-1:0] cnt;
      assign per_fire[j] = en && (cnt == P - TS_W'(1));
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     cnt <= '0;
        else if (en) cnt <= per_fire[j] ? '0 : cnt + TS_W'(1);
      end
    end else begin : g_none
      assign per_fire[j] = 1'b0;
    end
  end

  assign in_mask = en ? new_input : '0;
  assign q_push  = (|in_mask) | (|per_fire);

  ev_entry_t push_data, head, cur;
  logic      fifo_empty, fifo_full;

  assign push_data    = '{ts: ts, in_mask: in_mask, per_mask: per_fire};
  assign q_push_valid = q_push && (!fifo_full || q_pop);
  assign q_pop_valid  = q_pop && !fifo_empty;

  sched_event_fifo #(
    .W     ($bits(ev_entry_t)),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .wdata (push_data),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  sched_state_t   state, state_nx;
  logic [LW-1:0]  layer, layer_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      layer <= '0;
    end else begin
      state <= state_nx;
      layer <= layer_nx;
    end
  end

  always_comb begin
    state_nx = state;
    layer_nx = layer;
    if (en) begin
      case (state)
        ST_IDLE: if (!fifo_empty) state_nx = ST_LOAD;
        ST_LOAD: begin
          state_nx = ST_EVAL;
          layer_nx = '0;
        end
        ST_EVAL: begin
          if (layer == LW'(NUM_LAYERS-1)) state_nx = ST_IDLE;
          else                            layer_nx = layer + LW'(1);
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= '0;
      overflow <= 1'b0;
    end else begin
      if (q_pop) cur <= head;
      if (q_push && !q_push_valid) overflow <= 1'b1;
    end
  end

  assign ev_timestamp = cur.ts;

  logic [MAX_OUT-1:0] periodic_w, per_w, dep_w, act_w;
  logic [N_OUT-1:0]   active;

  always_comb begin
    periodic_w = '0;
    per_w      = '0;
    dep_w      = '0;
    for (int j = 0; j < N_OUT; j++) begin
      periodic_w[j] = periodic[j];
      per_w[j]      = cur.per_mask[j];
      dep_w[j]      = |(cur.in_mask & DEP_IN[j*N_IN +: N_IN]);
    end
    act_w  = active_mask(periodic_w, per_w, dep_w);
    active = act_w[N_OUT-1:0];
  end

  always_comb begin
    q_pop      = en && (state == ST_IDLE) && !fifo_empty;
    busy       = (state != ST_IDLE);
    enable_in  = '0;
    enable_out = '0;
    if (en && state == ST_LOAD) enable_in = cur.in_mask;
    if (en && state == ST_EVAL) begin
      for (int j = 0; j < N_OUT; j++)
        enable_out[j] = active[j] && (LAYER_OF[j*8 +: 8] == 8'(layer));
    end
  end

endmodule

// File: tb/tb_stream_eval_scheduler.sv
// Randomised and directed bench for stream_eval_scheduler against an event-queue reference model.
// Output 3 is periodic (every 100 cycles); outputs 0-2 are driven by the single input.
module tb_stream_eval_scheduler;

  localparam int N_IN  = 1;
  localparam int N_OUT = 4;
  localparam int TS_W  = 32;
  localparam int QD    = 4;
  localparam int NL    = 3;
  localparam logic [N_OUT*TS_W-1:0] PER = {32'd100, 32'd0, 32'd0, 32'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [N_IN-1:0]  new_input = '0;
  logic [N_IN-1:0]  enable_in;
  logic [N_OUT-1:0] enable_out;
  logic q_push, q_pop, q_push_valid, q_pop_valid, busy, overflow;
  logic [TS_W-1:0]  ev_timestamp;

  stream_eval_scheduler #(
    .N_IN(N_IN), .N_OUT(N_OUT), .TS_W(TS_W), .Q_DEPTH(QD), .NUM_LAYERS(NL), .PERIOD(PER)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .new_input(new_input),
    .enable_in(enable_in), .enable_out(enable_out),
    .q_push(q_push), .q_pop(q_pop), .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
    .ev_timestamp(ev_timestamp), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of events plus the position of the current event in its replay.
  typedef struct {
    int unsigned      ts;
    logic [N_IN-1:0]  im;
    logic [N_OUT-1:0] pm;
  } ev_t;

  ev_t         evq[$];
  ev_t         cur;
  int          tcount;
  int          phase;   // 0 idle, 1 load, 2.. eval of layer phase-2
  int unsigned m_ev_ts;
  logic        m_ovf;
  int          period_of[N_OUT] = '{0, 0, 0, 100};
  int          layer_of[N_OUT]  = '{0, 1, 1, 2};
  int          out3_count;
  int          push_count;

  task automatic model_reset();
    evq.delete();
    tcount  = 0;
    phase   = 0;
    m_ev_ts = 0;
    m_ovf   = 1'b0;
    cur     = '{0, '0, '0};
  endtask

  function automatic logic [N_OUT-1:0] active_of(input ev_t e);
    logic [N_OUT-1:0] a;
    for (int j = 0; j < N_OUT; j++)
      a[j] = (period_of[j] != 0) ? e.pm[j] : (|e.im);
    return a;
  endfunction

  task automatic cycle(input logic [N_IN-1:0] ni, input logic e);
    logic [N_OUT-1:0] per, eo, act;
    logic [N_IN-1:0]  ei;
    logic pop, push, acc;
    new_input = ni;
    en        = e;
    @(negedge clk);
    per = '0; eo = '0; ei = '0; pop = 1'b0; push = 1'b0; acc = 1'b0;
    if (e) begin
      for (int j = 0; j < N_OUT; j++)
        if (period_of[j] != 0 && (tcount % period_of[j]) == period_of[j] - 1) per[j] = 1'b1;
      pop = (phase == 0) && (evq.size() > 0);
      if (phase == 1) ei = cur.im;
      else if (phase >= 2) begin
        act = active_of(cur);
        for (int j = 0; j < N_OUT; j++)
          if (act[j] && layer_of[j] == phase - 2) eo[j] = 1'b1;
      end
      push = (|ni) || (|per);
      acc  = push && (evq.size() < QD || pop);
    end
    check_eq("q_push", q_push, push);
    check_eq("q_push_valid", q_push_valid, acc);
    check_eq("q_pop", q_pop, pop);
    check_eq("q_pop_valid", q_pop_valid, pop);
    check_eq("enable_in", enable_in, ei);
    check_eq("enable_out", enable_out, eo);
    check_eq("busy", busy, phase != 0);
    check_eq("ev_timestamp", ev_timestamp, m_ev_ts);
    check_eq("overflow", overflow, m_ovf);
    if (enable_out[3]) out3_count++;
    if (q_push) push_count++;
    if (e) begin
      if (pop) begin
        cur     = evq.pop_front();
        m_ev_ts = cur.ts;
      end
      if (acc) evq.push_back('{tcount, ni, per});
      if (push && !acc) m_ovf = 1'b1;
      if (phase == 0) phase = pop ? 1 : 0;
      else            phase = (phase == NL + 1) ? 0 : phase + 1;
      tcount++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_enable_in"}, enable_in, 0);
    check_eq({tag, "_enable_out"}, enable_out, 0);
    check_eq({tag, "_q_push"}, q_push, 0);
    check_eq({tag, "_q_pop"}, q_pop, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_overflow"}, overflow, 0);
    check_eq({tag, "_ev_timestamp"}, ev_timestamp, 0);
  endtask

  initial begin
    logic found;
    model_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // Periodic output 3 with one merged arrival at 99 and an isolated arrival at 150.
    out3_count = 0;
    push_count = 0;
    for (int c = 0; c < 320; c++)
      cycle(N_IN'((c == 99) || (c == 150)), 1'b1);
    check_eq("out3_eval_count", out3_count, 3);
    check_eq("phase_a_pushes", push_count, 4);

    // Burst of 20 arrivals overruns the queue.
    for (int c = 0; c < 20; c++) cycle('1, 1'b1);
    for (int c = 0; c < 30; c++) cycle('0, 1'b1);
    check_eq("overflow_sticky", overflow, 1);

    for (int c = 0; c < 300; c++)
      cycle(N_IN'($urandom_range(0, 4) == 0), $urandom_range(0, 9) != 0);

    // Freeze with en=0 in the middle of EVAL_1.
    cycle('1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (phase == 3) found = 1'b1;
      else            cycle('0, 1'b1);
    end
    check_eq("reach_eval1", found, 1);
    for (int c = 0; c < 10; c++) cycle('1, 1'b0);
    for (int c = 0; c < 10; c++) cycle('0, 1'b1);

    // Reset pulse in the middle of LOAD with events still queued.
    for (int c = 0; c < 3; c++) cycle('1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (phase == 1) found = 1'b1;
      else            cycle('0, 1'b1);
    end
    check_eq("reach_load", found, 1);
    new_input = '0;
    en        = 1'b1;
    @(negedge clk);
    check_eq("load_enable_in", enable_in, (phase == 1) ? cur.im : '0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_load_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 20; c++) cycle('0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_eval_scheduler.md
Name: stream_eval_scheduler

Overview:
- Sequences evaluation of the generated RTLola monitor datapath.
- Merges event-driven input arrivals and periodic deadlines into timestamped evaluation events and buffers them in a small FIFO.
- Replays each event as a fixed schedule: one input-latch cycle, then one cycle per evaluation layer, driving per-stream enables.
- Sits between the monitor's input interface and the stream datapath, and produces the enable_in*/enable_out* and q_push/q_pop status signals.

Parameters:
- N_IN, 1, number of input streams.
- N_OUT, 4, number of output streams.
- TS_W, 32, timestamp/counter width.
- Q_DEPTH, 4, event FIFO depth; power of two, ≥2.
- NUM_LAYERS, 3, evaluation layers; ≥1.
- PERIOD, packed N_OUT×TS_W, default all 0: per-output period in cycles; 0 marks the output as event-driven.
- LAYER_OF, packed N_OUT×8, default {0,1,1,2}: layer index of each output; every value < NUM_LAYERS.
- DEP_IN, packed N_OUT×N_IN, default all 1: input mask that triggers each event-driven output.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  global enable; low freezes all state.
- new_input  in  N_IN  per-input arrival strobe.
- enable_in  out  N_IN  latch input j into the datapath.
- enable_out  out  N_OUT  evaluate output j this cycle.
- q_push  out  1  an event was formed this cycle.
- q_pop  out  1  the FSM requested a pop this cycle.
- q_push_valid  out  1  push accepted.
- q_pop_valid  out  1  pop delivered an entry.
- ev_timestamp  out  TS_W  timestamp of the event being evaluated.
- busy  out  1  FSM not IDLE.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; timestamp counter and period counters 0.
- Global enable: en=0 freezes the counters, FIFO and FSM. While en=0, q_push, q_pop, enable_in and enable_out are all 0.
- Timestamp: free-running TS_W counter, +1 per enabled cycle, wraps modulo 2^TS_W.
- Periodic outputs (PERIOD[j]≠0): counter 0..PERIOD-1. The output fires in the cycle its count equals PERIOD-1, and the counter then returns to 0. First fire is at enabled cycle PERIOD-1 after reset.
- Event formation, cycle t:
  - in_mask = new_input; per_mask = periodic fires.
  - q_push = |in_mask | |per_mask|.
  - Entry = {ts, in_mask, per_mask}; ts is the counter value in cycle t.
  - Simultaneous input and deadline produce ONE merged entry.
- Push acceptance: q_push_valid = q_push & (!full | pop this cycle).
- Dropped event: sets overflow (sticky until rst). No other effect.
- Pop: q_pop is asserted in IDLE when the FIFO is non-empty. q_pop_valid = q_pop & !empty, so both are asserted together. Push into an empty FIFO is visible to pop on the next cycle only; no fall-through.
- FSM states:
  - IDLE: if non-empty, pop and latch the entry, go to LOAD.
  - LOAD (1 cycle): enable_in = in_mask.
  - EVAL_k for k=0..NUM_LAYERS-1 (1 cycle each): enable_out[j] = active[j] & (LAYER_OF[j]==k).
  - active[j] = per_mask[j] when PERIOD[j]≠0; otherwise |(in_mask & DEP_IN[j]).
  - After EVAL_{NUM_LAYERS-1}: go to IDLE.
- Latency: event formed at t with FIFO empty and FSM IDLE gives pop at t+1, LOAD at t+2, EVAL_k at t+3+k.
- Throughput: one event per NUM_LAYERS+2 cycles.
- ev_timestamp: held from the pop until the next pop.
- busy: 1 in LOAD/EVAL.
- Empty layers: a layer with no active outputs still consumes its cycle, with enable_out=0.
- Reset mid-operation: asynchronous return to the reset state; in-flight and queued events are discarded.

Decomposition:
- Package stream_sched_pkg:
  - FSM state enum.
  - Event entry struct {ts, in_mask, per_mask}.
  - Function computing the active mask from the DEP_IN/PERIOD parameters.
- Sub-module sched_event_fifo:
  - Parameterised width/depth.
  - Registered storage and pointers; full/empty flags.
  - Simultaneous push/pop supported.
- Period counters and FSM stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles → all outputs 0, ev_timestamp=0; releasing rst produces no spurious enable.
- Defaults, new_input=1 at t=100:
  - t=100: q_push=1, q_push_valid=1.
  - t=101: q_pop=1, q_pop_valid=1.
  - t=102: enable_in=1.
  - t=103: enable_out=0001; t=104: 0110; t=105: 1000.
  - ev_timestamp=100.
- PERIOD={0,0,0,100}, no inputs → output 3 evaluated every 100 cycles: first EVAL_2 at cycle 104, then 204, 304; outputs 0–2 never enabled.
- Same PERIOD, new_input=1 at cycle 99 → single merged entry (q_push once, one pop); EVAL_2 at 104 enables output 3 once; outputs 0–2 also enabled in their layers.
- Q_DEPTH=4, new_input held high 20 cycles → q_push_valid drops when full; overflow=1 and stays 1; exactly the accepted entries are evaluated, in order, with increasing timestamps.
- en=0 for 10 cycles mid-EVAL_1 → enables forced 0 and state frozen; resumes at EVAL_1 with unchanged ev_timestamp. Separately, rst pulse mid-LOAD → outputs 0 immediately and FIFO empty afterwards.
